uart_tx_feeder: RTL

Transmit-side buffer that sits directly upstream of the UART transmitter on the `t_clk` domain. It accepts bytes from a host write port into a FIFO and presents them one at a time to the transmitter over the `UART_Tx_RQST` / `Tx_DATA` / `UART_Tx_READY_BUSY` handshake. It also reports FIFO occupancy and a sticky overflow error.

---
 rtl/uart_tx_feeder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - transmit FIFO feeding the UART transmitter over a request/ready handshake
//
// Buffers host bytes in a FIFO and hands them one at a time to the UART
// transmitter, reporting occupancy and a sticky dropped-write error.
//
// Ports:
//   t_clk, t_rst          clock; synchronous active-low reset
//   wr_en, wr_data        host write strobe and byte
//   fifo_full/fifo_empty  occupancy flags (count == DEPTH / count == 0)
//   fifo_count            number of stored words
//   ovf_err, ovf_clr      sticky "write dropped" flag and its clear
//   UART_Tx_READY_BUSY    transmitter status, 1 = idle/ready, 0 = busy
//   UART_Tx_RQST          registered transmit request
//   Tx_DATA               registered byte presented to the transmitter

`ifndef WORD_LENGTH
`define WORD_LENGTH 8
`endif

module uart_tx_feeder #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int BUSY_TO = 4
) (
  input  logic                    t_clk,
  input  logic                    t_rst,
  input  logic                    wr_en,
  input  logic [`WORD_LENGTH-1:0] wr_data,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic [AW:0]             fifo_count,
  output logic                    ovf_err,
  input  logic                    ovf_clr,
  input  logic                    UART_Tx_READY_BUSY,
  output logic                    UART_Tx_RQST,
  output logic [`WORD_LENGTH-1:0] Tx_DATA
);

  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_BUSY, S_WAIT_RDY} state_t;

  logic [`WORD_LENGTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q, count_d;
  logic                    ovf_q, ovf_d;
  state_t                  state_q, state_d;
  logic [TW-1:0]           to_cnt_q, to_cnt_d;
  logic                    rqst_q, rqst_d;
  logic [`WORD_LENGTH-1:0] data_q, data_d;
  logic                    full, empty, wr_ok, wr_drop, pop;

  // Fullness comes from the registered count, so a write while full is
  // dropped even when a pop happens on the same edge.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign wr_ok   = wr_en && !full;
  assign wr_drop = wr_en && full;
  assign pop     = (state_q == S_REQ) && UART_Tx_READY_BUSY;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Setting wins over clearing so a drop in the clear cycle is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge t_clk) begin
    if (!t_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset; the cleared pointers make old contents unreachable.
  always_ff @(posedge t_clk) begin
    if (t_rst && wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge t_clk) begin
    if (!t_rst) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      rqst_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      rqst_q   <= rqst_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!empty) state_d = S_REQ;
      S_REQ:       if (UART_Tx_READY_BUSY) state_d = S_WAIT_BUSY;
      // A transmitter that never shows busy still releases the feeder after
      // BUSY_TO cycles; the word is treated as sent.
      S_WAIT_BUSY: begin
        if (!UART_Tx_READY_BUSY) begin
          state_d = S_WAIT_RDY;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RDY:  if (UART_Tx_READY_BUSY) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rqst_d   = rqst_q;
    data_d   = data_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          rqst_d = 1'b1;
          data_d = mem_q[rd_ptr_q];
        end
      end
      S_REQ: begin
        if (UART_Tx_READY_BUSY) begin
          rqst_d   = 1'b0;
          to_cnt_d = '0;
        end
      end
      S_WAIT_BUSY: begin
        if (UART_Tx_READY_BUSY) to_cnt_d = to_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign fifo_full    = full;
  assign fifo_empty   = empty;
  assign fifo_count   = count_q;
  assign ovf_err      = ovf_q;
  assign UART_Tx_RQST = rqst_q;
  assign Tx_DATA      = data_q;

endmodule
